// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants and FSM encoding for the UART transmit feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int STAT_W       = 16;

  // 2-bit state encoding kept as plain constants so older tools can consume it.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t WAIT = 2'd2;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host-push and transmitter-handshake bundle of the UART transmit feeder.
// Latency: n/a (wires only). Optional stats signals under UART_TX_FEEDER_STATS_EN.
// Backpressure: host watches full/overflow; transmitter paces via baudratetx/tx_done.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int Data_length = DATA_LEN_DEF,
  parameter int ADDR_W      = 4
);
  logic                   wr_en;
  logic [Data_length-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        count;
  logic                   overflow;
  logic                   baudratetx;
  logic                   tx_done;
  logic [Data_length-1:0] parallel_datain;
  logic                   send;
  logic                   busy;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [STAT_W-1:0]      frames_sent;
  logic [STAT_W-1:0]      drops;
`endif

  // Feeder side.
  modport slave (
    input  wr_en, wr_data, baudratetx, tx_done,
    output full, empty, count, overflow, parallel_datain, send, busy
`ifdef UART_TX_FEEDER_STATS_EN
    , output frames_sent, drops
`endif
  );

  // Host / transmitter side.
  modport master (
    output wr_en, wr_data, baudratetx, tx_done,
    input  full, empty, count, overflow, parallel_datain, send, busy
`ifdef UART_TX_FEEDER_STATS_EN
    , input frames_sent, drops
`endif
  );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Circular-buffer FIFO with separately tracked occupancy; caller guards push/pop.
// Latency: written word is readable on rdata the cycle after the push (no write-through).
// Backpressure: full/empty are registered-derived; push at full or pop at empty is not checked here.
module uart_sync_fifo #(
  parameter int Data_length = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Data_length-1:0] wdata,
  output logic [Data_length-1:0] rdata,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty
);

  logic [Data_length-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wptr_q, wptr_d;
  logic [ADDR_W-1:0]      rptr_q, rptr_d;
  logic [ADDR_W:0]        count_q, count_d;

  // Next pointer/occupancy values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + ADDR_W'(1);
    if (pop)  rptr_d = rptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches one UART frame per byte on baud edges. Stats macro: UART_TX_FEEDER_STATS_EN.
// Latency: send rises the cycle after a detected baud rise; push-to-send is 1 cycle plus the wait for that rise.
// Backpressure: host push dropped with a 1-cycle overflow pulse when full and not popping; frames wait for tx_done.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int Data_length = DATA_LEN_DEF,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4
) (
  input logic              tx_clk,
  input logic              rst,
  uart_tx_feeder_if.slave  bus
);

  logic                   baud_q, done_q;
  logic                   base_rise, done_rise;
  state_t                 state_q, state_d;
  logic                   send_q, send_d;
  logic [Data_length-1:0] pdata_q, pdata_d;
  logic                   fifo_push, fifo_pop;
  logic [Data_length-1:0] fifo_rdata;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_full, fifo_empty;

  assign base_rise = bus.baudratetx & ~baud_q;
  assign done_rise = bus.tx_done & ~done_q;

  // A pop happens only as part of a launch; a push at full is still taken when that pop frees a slot.
  assign fifo_pop  = (state_q == IDLE) & base_rise & ~fifo_empty;
  assign fifo_push = bus.wr_en & (~fifo_full | fifo_pop);

  uart_sync_fifo #(
    .Data_length (Data_length),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_fifo (
    .clk   (tx_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.wr_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Launch/wait sequencing: the send pulse spans exactly one baud period, then wait for end of frame.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    pdata_d = pdata_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          pdata_d = fifo_rdata;
          send_d  = 1'b1;
          state_d = SEND;
        end else begin
          send_d  = 1'b0;
        end
      end
      SEND: begin
        if (base_rise) begin
          send_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done_rise) state_d = IDLE;
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Edge-detect history and FSM/output registers.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      baud_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= IDLE;
      send_q  <= 1'b0;
      pdata_q <= '0;
    end else begin
      baud_q  <= bus.baudratetx;
      done_q  <= bus.tx_done;
      state_q <= state_d;
      send_q  <= send_d;
      pdata_q <= pdata_d;
    end
  end

  assign bus.full            = fifo_full;
  assign bus.empty           = fifo_empty;
  assign bus.count           = fifo_count;
  assign bus.overflow        = bus.wr_en & fifo_full & ~fifo_pop;
  assign bus.parallel_datain = pdata_q;
  assign bus.send            = send_q;
  assign bus.busy            = (state_q != IDLE);

`ifdef UART_TX_FEEDER_STATS_EN
  logic [STAT_W-1:0] frames_q, drops_q;
  logic              frame_evt;

  assign frame_evt = (state_q == SEND) & base_rise;

  // Saturating frame and drop counters.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (frame_evt && frames_q != '1)    frames_q <= frames_q + STAT_W'(1);
      if (bus.overflow && drops_q != '1)  drops_q  <= drops_q + STAT_W'(1);
    end
  end

  assign bus.frames_sent = frames_q;
  assign bus.drops       = drops_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench: modelled baud/tx_done source, scoreboard on send launches, table-driven fill test.
// Latency: n/a.
// Backpressure: tx_done can be stalled to hold the feeder in WAIT.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BAUD  = 8;

  logic tx_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tx_clk = ~tx_clk;

  uart_tx_feeder_if #(.Data_length(DW), .ADDR_W(AW)) bif();

  uart_tx_feeder #(.Data_length(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .bus    (bif)
  );

  typedef struct {
    logic [7:0] dat;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] sb_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         bcnt   = BAUD - 1;
  logic       baud_rose = 1'b0;
  logic       stall  = 1'b0;
  int         done_cnt = 0;
  int         tx_hi  = 0;
  logic       send_prev = 1'b0;
  logic       in_send = 1'b0;
  int         send_w = 0;
  int         n_send = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: sample DUT just after the edge, then advance the transmitter model.
  task automatic cyc();
    @(posedge tx_clk);
    #1;
    if (bif.send && !send_prev) begin
      check("send_with_queue", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) check("send_data", bif.parallel_datain, sb_q.pop_front());
      n_send++;
      send_w  = 0;
      in_send = 1'b1;
    end
    if (in_send) begin
      if (bif.send) send_w++;
      else begin
        check("send_width", send_w, BAUD);
        check("busy_in_wait", bif.busy, 1);
        in_send = 1'b0;
      end
    end
    send_prev = bif.send;
    bcnt = (bcnt + 1) % BAUD;
    baud_rose = (bcnt == 0);
    bif.baudratetx = (bcnt < 2);
    if (bif.tx_done) begin
      tx_hi++;
      if (tx_hi >= 2) begin bif.tx_done = 1'b0; tx_hi = 0; end
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bif.tx_done = 1'b1;
    end else if (bif.busy && !bif.send && !stall) begin
      done_cnt = 3;
    end
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int i;
    i = 0;
    while ((bif.busy || sb_q.size() != 0 || bif.tx_done) && i < lim) begin
      cyc();
      i++;
    end
    check(nm, (i < lim), 1);
  endtask

  task automatic push(input logic [7:0] d);
    bif.wr_en   = 1'b1;
    bif.wr_data = d;
    sb_q.push_back(d);
    cyc();
    bif.wr_en   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n0;
    logic found;
    for (int i = 0; i < 17; i++) begin
      tbl[i].dat   = 8'h10 + 8'(i);
      tbl[i].cnt   = (i < 16) ? i + 1 : 16;
      tbl[i].full  = (i >= 15);
      tbl[i].empty = 1'b0;
      tbl[i].ovf   = (i == 16);
    end
    bif.wr_en = 1'b0; bif.wr_data = '0; bif.baudratetx = 1'b0; bif.tx_done = 1'b0;

    // Reset state
    #20;
    check("rst_send", bif.send, 0);
    check("rst_pdata", bif.parallel_datain, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_count", bif.count, 0);
    check("rst_empty", bif.empty, 1);
    check("rst_full", bif.full, 0);
    check("rst_overflow", bif.overflow, 0);
`ifdef UART_TX_FEEDER_STATS_EN
    check("rst_frames", bif.frames_sent, 0);
    check("rst_drops", bif.drops, 0);
`endif
    @(posedge tx_clk); #1; rst = 1'b0;
    cyc(); cyc();

    // Single byte into an idle feeder
    push(8'h01);
    check("single_count", bif.count, 1);
    found = 1'b0;
    for (int i = 0; i < 2 * BAUD && !found; i++) begin
      if (baud_rose) begin
        cyc();
        check("send_after_baud", bif.send, 1);
        found = 1'b1;
      end else cyc();
    end
    check("single_send_seen", found, 1);
    wait_idle("single_done", 100);
    check("single_empty", bif.empty, 1);
    check("single_nsend", n_send, 1);

    // Back-to-back burst
    n0 = n_send;
    for (int i = 0; i < 8; i++) push(8'((1 << (i + 1)) - 1));
    wait_idle("burst_done", 400);
    check("burst_nsend", n_send - n0, 8);

    // Fill while stalled in WAIT
    stall = 1'b1;
    push(8'hEE);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = bif.busy && !bif.send;
    end
    check("reach_wait", found, 1);
    for (int i = 0; i < 17; i++) begin
      bif.wr_en   = 1'b1;
      bif.wr_data = tbl[i].dat;
      #1;
      check("fill_overflow", bif.overflow, tbl[i].ovf);
      if (!tbl[i].ovf) sb_q.push_back(tbl[i].dat);
      cyc();
      bif.wr_en = 1'b0;
      check("fill_count", bif.count, tbl[i].cnt);
      check("fill_full", bif.full, tbl[i].full);
      check("fill_empty", bif.empty, tbl[i].empty);
    end
    #1;
    check("overflow_one_cycle", bif.overflow, 0);
`ifdef UART_TX_FEEDER_STATS_EN
    check("stats_drops", bif.drops, 1);
`endif

    // Push and pop together at full
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      found = !bif.busy && baud_rose;
    end
    check("idle_at_full", found, 1);
    bif.wr_en   = 1'b1;
    bif.wr_data = 8'h5A;
    #1;
    check("pushpop_overflow", bif.overflow, 0);
    sb_q.push_back(8'h5A);
    cyc();
    bif.wr_en = 1'b0;
    check("pushpop_count", bif.count, 16);
    check("pushpop_send", bif.send, 1);
    wait_idle("drain_done", 1000);
    check("drain_empty", bif.empty, 1);
`ifdef UART_TX_FEEDER_STATS_EN
    check("stats_frames", bif.frames_sent, 27);
`endif

    // Reset while in SEND with 5 bytes queued
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    found = bif.send;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = bif.send;
    end
    check("midframe_send", found, 1);
    check("midframe_count", bif.count, 5);
    #2; rst = 1'b1;
    #1;
    check("arst_send", bif.send, 0);
    check("arst_count", bif.count, 0);
    check("arst_empty", bif.empty, 1);
    check("arst_busy", bif.busy, 0);
`ifdef UART_TX_FEEDER_STATS_EN
    check("arst_frames", bif.frames_sent, 0);
`endif
    sb_q.delete();
    in_send = 1'b0; send_prev = 1'b0;
    done_cnt = 0; tx_hi = 0; bif.tx_done = 1'b0;
    @(posedge tx_clk); #1; rst = 1'b0;
    n0 = n_send;
    for (int i = 0; i < 4 * BAUD; i++) cyc();
    check("no_send_after_rst", n_send - n0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
